// File: rtl/cdr_pkg.sv
// Shared definitions for the CDR bang-bang phase detector / vote decimator.
//   PD_WIDTH     - default samples per word
//   PD_VOTE_WIN  - default valid words per decision window
//   PD_THRESH    - default minimum |net vote| for an up/dn pulse
//   net_w()      - signed width that holds any window net vote
//   pd_dec_t     - decision encoding for benches and monitors
package cdr_pkg;

  localparam int unsigned PD_WIDTH    = 10;
  localparam int unsigned PD_VOTE_WIN = 4;
  localparam int unsigned PD_THRESH   = 2;

  // Magnitude never exceeds width*win, plus one sign bit.
  function automatic int unsigned net_w(input int unsigned width, input int unsigned win);
    return $clog2(width * win + 1) + 1;
  endfunction

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } pd_dec_t;

endpackage

// File: rtl/cdr_pd_count.sv
// Combinational early/late vote count for one word of Alexander phase-detector samples.
//   data_smp  - data samples, bit 0 oldest
//   edge_smp  - edge samples, edge_smp[i] between d[i-1] and data_smp[i]
//   d_last    - last data bit of the previous valid word (d[-1])
//   prev_ok   - d_last is meaningful; pair i=0 is skipped when low
//   early_cnt - number of early votes in this word
//   late_cnt  - number of late votes in this word
module cdr_pd_count
  import cdr_pkg::*;
#(
  parameter int unsigned WIDTH = PD_WIDTH,
  localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_smp,
  input  logic [WIDTH-1:0] edge_smp,
  input  logic             d_last,
  input  logic             prev_ok,
  output logic [CW-1:0]    early_cnt,
  output logic [CW-1:0]    late_cnt
);

  logic d_prev;
  logic pair_ok;

  always_comb begin
    early_cnt = '0;
    late_cnt  = '0;
    d_prev    = 1'b0;
    pair_ok   = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i == 0) begin
        d_prev  = d_last;
        pair_ok = prev_ok;
      end else begin
        d_prev  = data_smp[i-1];
        pair_ok = 1'b1;
      end
      // On a transition the edge sample matches exactly one neighbour:
      // matching the older bit means the clock sampled early.
      if (pair_ok && (d_prev != data_smp[i])) begin
        if (edge_smp[i] == d_prev) begin
          early_cnt = early_cnt + CW'(1);
        end else begin
          late_cnt = late_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cdr_bbpd_voter.sv
// Bang-bang phase detector with vote decimation for the RX CDR loop.
// Two pipeline stages: stage 1 registers per-word early/late counts, stage 2
// accumulates them over VOTE_WIN valid words and issues at most one up/dn pulse.
//   clk      - sample-word clock
//   rst_n    - synchronous active-low reset
//   data_smp - data samples, bit 0 oldest
//   edge_smp - interleaved edge samples
//   in_valid - word valid this cycle
//   up       - one-cycle pulse, net vote >= THRESH
//   dn       - one-cycle pulse, net vote <= -THRESH
//   win_done - one-cycle pulse at every window end
//   net_vote - signed net vote of the last completed window
module cdr_bbpd_voter
  import cdr_pkg::*;
#(
  parameter int unsigned WIDTH    = PD_WIDTH,
  parameter int unsigned VOTE_WIN = PD_VOTE_WIN,
  parameter int unsigned THRESH   = PD_THRESH,
  localparam int unsigned NW      = net_w(WIDTH, VOTE_WIN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_smp,
  input  logic [WIDTH-1:0]     edge_smp,
  input  logic                 in_valid,
  output logic                 up,
  output logic                 dn,
  output logic                 win_done,
  output logic signed [NW-1:0] net_vote
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = (VOTE_WIN > 1) ? $clog2(VOTE_WIN) : 1;
  localparam int          ThreshI = int'(THRESH);

  // Boundary history, held across in_valid gaps
  logic d_last_q;
  logic prev_ok_q;

  logic [CW-1:0] early_cnt;
  logic [CW-1:0] late_cnt;

  // Stage 1
  logic [CW-1:0] e_q;
  logic [CW-1:0] l_q;
  logic          s1_valid_q;

  // Stage 2
  logic signed [NW-1:0] acc_q, acc_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic signed [NW-1:0] net_q, net_d;
  logic                 up_q, up_d;
  logic                 dn_q, dn_d;
  logic                 win_done_q, win_done_d;

  logic signed [NW-1:0] diff;
  logic signed [NW-1:0] net_sum;

  cdr_pd_count #(
    .WIDTH (WIDTH)
  ) u_pd_count (
    .data_smp  (data_smp),
    .edge_smp  (edge_smp),
    .d_last    (d_last_q),
    .prev_ok   (prev_ok_q),
    .early_cnt (early_cnt),
    .late_cnt  (late_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_last_q   <= 1'b0;
      prev_ok_q  <= 1'b0;
      e_q        <= '0;
      l_q        <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        d_last_q  <= data_smp[WIDTH-1];
        prev_ok_q <= 1'b1;
        e_q       <= early_cnt;
        l_q       <= late_cnt;
      end
    end
  end

  // Counts are zero-extended before subtraction; NW is wider than CW.
  assign diff    = $signed(NW'(e_q)) - $signed(NW'(l_q));
  assign net_sum = acc_q + diff;

  always_comb begin
    acc_d      = acc_q;
    beat_d     = beat_q;
    net_d      = net_q;
    up_d       = 1'b0;
    dn_d       = 1'b0;
    win_done_d = 1'b0;
    if (s1_valid_q) begin
      if (beat_q == BW'(VOTE_WIN - 1)) begin
        acc_d      = '0;
        beat_d     = '0;
        net_d      = net_sum;
        win_done_d = 1'b1;
        up_d       = (int'(net_sum) >= ThreshI);
        dn_d       = (int'(net_sum) <= -ThreshI);
      end else begin
        acc_d  = net_sum;
        beat_d = beat_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      beat_q     <= '0;
      net_q      <= '0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      win_done_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      beat_q     <= beat_d;
      net_q      <= net_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      win_done_q <= win_done_d;
    end
  end

  assign up       = up_q;
  assign dn       = dn_q;
  assign win_done = win_done_q;
  assign net_vote = net_q;

endmodule

// File: doc/cdr_bbpd_voter.md
# cdr_bbpd_voter

Bang-bang (Alexander) phase detector and vote decimator for the PMA RX clock-data-recovery loop; it produces the `up`/`dn` decisions consumed by the digital loop filter that drives the 11-bit phase-interpolator code. Each clock it takes one parallel word of data samples and interleaved edge samples, counts early/late transitions and accumulates them over a fixed window. At each window end it issues at most one registered `up` or `dn` pulse.

## Interface
- `WIDTH`, 10: data/edge samples per word.
- `VOTE_WIN`, 4: valid words per decision window (≥1).
- `THRESH`, 2: minimum |net vote| for a pulse (≥1).
- `clk`  in  1  sample-word clock.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `data_smp`  in  WIDTH  data samples, bit 0 oldest.
- `edge_smp`  in  WIDTH  edge samples; `edge_smp[i]` lies between `d[i-1]` and `data_smp[i]`.
- `in_valid`  in  1  word valid this cycle.
- `up`  out  1  one-cycle pulse: net early ≥ THRESH; advance loop-filter code.
- `dn`  out  1  one-cycle pulse: net late ≤ −THRESH.
- `win_done`  out  1  one-cycle pulse at every window end, with or without a decision.
- `net_vote`  out  NW signed  net vote of the last completed window; NW = $clog2(WIDTH*VOTE_WIN+1)+1.

## Operation
- `d[-1]` is the last data bit of the previous valid word. It is held across `in_valid`=0 gaps. `prev_ok` is cleared by reset and set after the first valid word.
- For each i in 0..WIDTH-1, with `d[i-1]` ≠ `d[i]` (transition): early vote if `e[i]` == `d[i-1]`; late vote if `e[i]` == `d[i]`. No transition means no vote. Pair i=0 is skipped while `prev_ok`=0.
- Stage 1: register early count E and late count L (0..WIDTH each) and a valid flag.
- Stage 2: accumulate `acc += E − L` on each stage-1 valid. Beat counter runs 0..VOTE_WIN−1.
- Window end (stage-1 valid with counter = VOTE_WIN−1):
  - `net` = acc + E − L.
  - Register `net_vote` = net and pulse `win_done`.
  - `up` = (net ≥ THRESH); `dn` = (net ≤ −THRESH).
  - Clear acc; counter wraps to 0.
- `up` and `dn` are never high together. The accumulator cannot overflow at width NW, so no saturation.
- `in_valid`=0: no vote, counters hold, stage-1 valid = 0.
- Reset (any cycle, including mid-window): E, L, acc, counter, `prev_ok`, `d[-1]`, `up`, `dn`, `win_done` and `net_vote` all go to 0, and the pipeline flushes. The partial window is discarded.

## Timing
- Reset values: `up`=0, `dn`=0, `win_done`=0, `net_vote`=0.
- Latency: a word sampled at edge N that closes a window produces `up`/`dn`/`win_done`/`net_vote` updated at edge N+2.
- Each pulse is exactly one cycle wide; the minimum spacing between pulses is VOTE_WIN cycles.
- No backpressure; the loop filter samples every cycle.
- Valid words separated by gaps still count toward the same window. The window closes on the VOTE_WIN-th valid word.

## Structure
- Shared package `cdr_pkg` holds:
  - constants `PD_WIDTH` = 10, `PD_VOTE_WIN` = 4, `PD_THRESH` = 2;
  - function `net_w(width, win)` returning NW;
  - enum `pd_dec_t` {NONE, UP, DN} used by benches.
- Sub-module `cdr_pd_count`: combinational E/L popcount of one word given `d[-1]`/`prev_ok`. The top level owns both pipeline stages.

## Test plan
All scenarios use default parameters.
- Reset: `rst_n`=0 for 3 cycles with random inputs → `up`=`dn`=`win_done`=0 and `net_vote`=0 throughout.
- Early lock:
  - Stimulus: `data_smp`=10'b1010101010 every cycle, `in_valid`=1, edges equal to the previous bit.
  - Votes per word: 9 early on the first word, 10 on each word after.
  - Response: first window `net_vote`=39 with `up` pulse; each later window `net_vote`=40 with `up`.
  - `win_done` pulses every 4 cycles, each 2 clocks after the 4th word.
- Late lock: same data with edges equal to the current bit → `dn` pulses, `net_vote`=−39 then −40. `up` never asserts.
- Dead band and idle:
  - All-ones data → `net_vote`=0, `win_done` pulses, no `up`/`dn`.
  - A window with exactly one net early vote → `net_vote`=+1, no pulse.
- Gaps and reset:
  - `in_valid` pattern 1,0,0,1,1,0,1 with early data → single window close after the 7th cycle. `d[-1]` is held across gaps, so votes are 10 per word after the first.
  - `rst_n` pulsed low after 2 valid words → no pulse from those words. The next window needs 4 fresh words and gives `net_vote`=39.
